// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: pattern mode encoding,
// sequencer state encoding, and the seed/terminal patterns as functions of
// the LED count.
package led_pattern_pkg;

  // Widest LED bar the helper functions can describe.
  localparam int MAX_N = 64;

  localparam logic [MAX_N-1:0] LSB_ONE = {{(MAX_N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    SHIFT_R   = 3'd0,
    SHIFT_L   = 3'd1,
    FILL_R    = 3'd2,
    FILL_L    = 3'd3,
    SHIFT_OUT = 3'd4,
    SHIFT_IN  = 3'd5,
    FILL_OUT  = 3'd6,
    FILL_IN   = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All n LEDs lit.
  function automatic logic [MAX_N-1:0] ones_of(input int n);
    return (LSB_ONE << n) - LSB_ONE;
  endfunction

  // Fill modes accumulate lit LEDs; the others move a lit spot.
  function automatic logic is_fill(input mode_e m);
    return (m == FILL_R) || (m == FILL_L) || (m == FILL_OUT) || (m == FILL_IN);
  endfunction

  // First pattern shown when a sequence starts or reloads.
  function automatic logic [MAX_N-1:0] seed_of(input mode_e m, input int n);
    logic [MAX_N-1:0] s;
    case (m)
      SHIFT_R, FILL_R:     s = LSB_ONE << (n - 1);
      SHIFT_L, FILL_L:     s = LSB_ONE;
      SHIFT_OUT, FILL_OUT: s = (LSB_ONE << (n / 2)) | (LSB_ONE << (n / 2 - 1));
      SHIFT_IN, FILL_IN:   s = (LSB_ONE << (n - 1)) | LSB_ONE;
      default:             s = '0;
    endcase
    return s;
  endfunction

  // Pattern at which a sequence is complete: dark for shifts, full for fills.
  function automatic logic [MAX_N-1:0] terminal_of(input mode_e m, input int n);
    return is_fill(m) ? ones_of(n) : '0;
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Step-rate prescaler: one tick every period+1 enabled clock cycles.
// The count is compared against the live period value, so a shorter period
// written while the count is already past it runs the counter through
// all-ones and back to zero before the next tick.
module led_tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == period);

  // Count enabled cycles, restarting at zero on each tick.
  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == period) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: steps one of eight shift/fill patterns across an N-LED
// bar at a programmable rate, either looping or running once and parking.
// A change on the mode input restarts the engine from a dark bar.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             repeat_en,
  input  logic [DIV_W-1:0] period,
  output logic [N-1:0]     led,
  output logic             done,
  output logic             wrap
);

  localparam int HW = N / 2;

  logic [2:0]    mode_q;
  mode_e         cur_mode;
  state_e        state;
  logic          mode_chg;
  logic          tick;
  logic [N-1:0]  seed;
  logic [N-1:0]  terminal;
  logic [N-1:0]  next_led;
  logic [HW-1:0] hi;
  logic [HW-1:0] lo;

  assign cur_mode = mode_e'(mode_q);
  assign mode_chg = (mode != mode_q);
  assign seed     = N'(seed_of(cur_mode, N));
  assign terminal = N'(terminal_of(cur_mode, N));

  // A mode change restarts the step interval along with the pattern.
  led_tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset || mode_chg),
    .en     (en),
    .period (period),
    .tick   (tick)
  );

  // Next pattern for the registered mode; half-bar modes shift each half
  // independently so nothing crosses the centre.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    hi       = led[N-1:HW];
    lo       = led[HW-1:0];
    next_led = '0;
    case (cur_mode)
      SHIFT_R:   next_led = led >> 1;
      SHIFT_L:   next_led = led << 1;
      FILL_R:    next_led = (led >> 1) | seed;
      FILL_L:    next_led = (led << 1) | seed;
      SHIFT_OUT: next_led = {hi << 1, lo >> 1};
      SHIFT_IN:  next_led = {hi >> 1, lo << 1};
      FILL_OUT:  next_led = {hi << 1, lo >> 1} | seed;
      FILL_IN:   next_led = {hi >> 1, lo << 1} | seed;
      default:   next_led = '0;
    endcase
  end

  // Sequencer: reset, then mode change, then the step tick, in that priority.
  always_ff @(posedge clk) begin
    wrap <= 1'b0;
    if (reset) begin
      led    <= '0;
      done   <= 1'b0;
      state  <= ST_IDLE;
      mode_q <= mode;
    end else if (mode_chg) begin
      led    <= '0;
      done   <= 1'b0;
      state  <= ST_IDLE;
      mode_q <= mode;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          led   <= seed;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (led == '0) begin
            // Dark bar: end of a shift sequence, or the blank step a
            // looping fill inserts after the full bar.
            if (repeat_en) begin
              led  <= seed;
              wrap <= 1'b1;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else if (led == terminal) begin
            // Only fill modes reach a non-zero terminal.
            if (repeat_en) begin
              led <= '0;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else begin
            led <= next_led;
          end
        end
        ST_DONE: begin
          // Parked; turning looping on restarts from the seed.
          if (repeat_en) begin
            led   <= seed;
            wrap  <= 1'b1;
            done  <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          led   <= '0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: an 8-LED and a 12-LED instance share one
// stimulus stream and are each compared every cycle against a reference
// model that walks a precomputed list of pattern steps.
module tb_led_pattern_engine;

  localparam int PW   = 4;
  localparam int CMAX = 1 << PW;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  mode;
  logic        repeat_en;
  logic [PW-1:0] period;

  logic [7:0]  led8;
  logic        done8;
  logic        wrap8;
  logic [11:0] led12;
  logic        done12;
  logic        wrap12;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    int idx;   // -1: idle (dark); 0..len-1: list entry; len: blank fill step
    bit done;
    bit wrap;
    int cnt;
    int mq;
  } mstate_t;

  mstate_t m8;
  mstate_t m12;

  always #5 clk = ~clk;

  led_pattern_engine #(.N(8), .DIV_W(PW)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .repeat_en (repeat_en),
    .period    (period),
    .led       (led8),
    .done      (done8),
    .wrap      (wrap8)
  );

  led_pattern_engine #(.N(12), .DIV_W(PW)) dut12 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .repeat_en (repeat_en),
    .period    (period),
    .led       (led12),
    .done      (done12),
    .wrap      (wrap12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Number of entries in one pass of a pattern, terminal entry included.
  function automatic int seq_len(input int m, input int n);
    case (m)
      0, 1:    return n + 1;
      2, 3:    return n;
      4, 5:    return n / 2 + 1;
      default: return n / 2;
    endcase
  endfunction

  // Entry i of a pattern, written directly from the picture of each mode.
  function automatic int seq_val(input int m, input int n, input int i);
    int v = 0;
    int h = n / 2;
    case (m)
      0: v = (i < n) ? (1 << (n - 1 - i)) : 0;
      1: v = (i < n) ? (1 << i) : 0;
      2: v = ((1 << (i + 1)) - 1) << (n - 1 - i);
      3: v = (1 << (i + 1)) - 1;
      4: v = (i < h) ? ((1 << (h + i)) | (1 << (h - 1 - i))) : 0;
      5: v = (i < h) ? ((1 << (n - 1 - i)) | (1 << i)) : 0;
      6: for (int j = 0; j <= i; j++) v |= (1 << (h + j)) | (1 << (h - 1 - j));
      7: for (int j = 0; j <= i; j++) v |= (1 << (n - 1 - j)) | (1 << j);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_led(input mstate_t s, input int n);
    if (s.idx < 0 || s.idx >= seq_len(s.mq, n)) return 32'd0;
    return 32'(seq_val(s.mq, n, s.idx));
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input bit r, input int m, input bit e,
                                    input bit rp, input int p, input int n);
    mstate_t t = s;
    int      len;
    bit      fill;
    bit      tk;
    t.wrap = 1'b0;
    if (r || m != s.mq) begin
      t.idx = -1; t.done = 1'b0; t.cnt = 0; t.mq = m;
      return t;
    end
    if (!e) return t;
    tk    = (s.cnt == p);
    t.cnt = tk ? 0 : (s.cnt + 1) % CMAX;
    if (!tk) return t;
    len  = seq_len(s.mq, n);
    fill = (s.mq == 2) || (s.mq == 3) || (s.mq == 6) || (s.mq == 7);
    if (s.idx < 0) begin
      t.idx = 0;
    end else if (s.done) begin
      if (rp) begin t.idx = 0; t.wrap = 1'b1; t.done = 1'b0; end
    end else if (s.idx == len || (!fill && s.idx == len - 1)) begin
      if (rp) begin t.idx = 0; t.wrap = 1'b1; end
      else t.done = 1'b1;
    end else if (fill && s.idx == len - 1) begin
      if (rp) t.idx = len;
      else    t.done = 1'b1;
    end else begin
      t.idx = s.idx + 1;
    end
    return t;
  endfunction

  // One clock: apply inputs, advance both models, compare after the edge.
  task automatic step(input bit r, input int m, input bit e, input bit rp, input int p);
    reset     = r;
    mode      = 3'(m);
    en        = e;
    repeat_en = rp;
    period    = PW'(p);
    m8  = mstep(m8,  r, m, e, rp, p, 8);
    m12 = mstep(m12, r, m, e, rp, p, 12);
    @(posedge clk);
    #1;
    cyc_n++;
    check("n8.led",   32'(led8),   model_led(m8, 8));
    check("n8.done",  32'(done8),  32'(m8.done));
    check("n8.wrap",  32'(wrap8),  32'(m8.wrap));
    check("n12.led",  32'(led12),  model_led(m12, 12));
    check("n12.done", 32'(done12), 32'(m12.done));
    check("n12.wrap", 32'(wrap12), 32'(m12.wrap));
  endtask

  initial begin
    int exp_shift_r[10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h00};
    int wraps;
    int r_mode, r_rep, r_per;

    // Reset state.
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("reset.led", 32'(led8), 32'h0);
    check("reset.done", 32'(done8), 32'h0);

    // One-shot right shift at full rate, then park dark with done.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 0);
      check("shift_r.seq", 32'(led8), 32'(exp_shift_r[i]));
    end
    check("shift_r.done", 32'(done8), 32'h1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("shift_r.hold", 32'(led8), 32'h0);

    // Enabling looping while parked reloads the seed with a wrap pulse.
    step(0, 0, 1, 1, 0);
    check("rearm.led", 32'(led8), 32'h80);
    check("rearm.wrap", 32'(wrap8), 32'h1);
    check("rearm.done", 32'(done8), 32'h0);

    // Looping fill-left, a step every three cycles: exactly one wrap.
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 3, 1, 1, 2);
      if (wrap8) begin
        wraps++;
        check("fill_l.wrap_led", 32'(led8), 32'h01);
      end
    end
    check("fill_l.wrap_count", 32'(wraps), 32'd1);

    // Looping shift-out, then one-shot fill-in ending full.
    for (int i = 0; i < 12; i++) step(0, 4, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 7, 1, 0, 0);
    check("fill_in.led", 32'(led8), 32'hFF);
    check("fill_in.done", 32'(done8), 32'h1);

    // Pause mid-sequence, then resume on the same phase.
    for (int i = 0; i < 9; i++)  step(0, 1, 1, 1, 3);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 3);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 1, 3);

    // Mode change on a tick wins: dark, then the new seed next tick.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0);
    step(0, 2, 1, 1, 0);
    check("modechg.led", 32'(led8), 32'h00);
    step(0, 2, 1, 1, 0);
    check("modechg.seed", 32'(led8), 32'h80);

    // Shorter period written while the count is past it.
    for (int i = 0; i < 8; i++)  step(0, 0, 1, 1, 15);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1, 2);

    // Reset mid-run on the 12-LED bar, then restart.
    for (int i = 0; i < 5; i++) step(0, 5, 1, 1, 0);
    step(1, 5, 1, 1, 0);
    check("rst12.led", 32'(led12), 32'h000);
    check("rst12.done", 32'(done12), 32'h0);
    check("rst12.wrap", 32'(wrap12), 32'h0);
    step(0, 5, 1, 1, 0);
    check("rst12.seed", 32'(led12), 32'h801);

    // Randomized run against the models.
    r_mode = 0; r_rep = 1; r_per = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4)  r_mode = $urandom_range(7);
      if ($urandom_range(99) < 3)  r_rep  = $urandom_range(1);
      if ($urandom_range(99) < 5)  r_per  = $urandom_range(3);
      if ($urandom_range(99) < 1)  r_per  = $urandom_range(CMAX - 1);
      step(($urandom_range(199) == 0), r_mode, ($urandom_range(99) < 85), r_rep[0], r_per);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 Parameter N, default 8: LED count; SHALL be even and >= 4.
REQ-002 Parameter DIV_W, default 16: prescaler width.
REQ-003 clk  in  1  clock; all logic SHALL act on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  run/pause: 1 = pattern advances, 0 = pattern and prescaler frozen.
REQ-006 mode  in  3  pattern select, encoded per REQ-012.
REQ-007 repeat  in  1  1 = loop the pattern, 0 = one-shot.
REQ-008 period  in  DIV_W  step interval; one step every period+1 clk cycles.
REQ-009 led  out  N  LED drive, registered; led[N-1] is the leftmost LED.
REQ-010 done  out  1  high while a one-shot sequence is finished, registered.
REQ-011 wrap  out  1  one-cycle pulse on each repeat reload, registered.

Function
REQ-012 Modes SHALL be as follows (H = upper half [N-1:N/2], L = lower half [N/2-1:0]):
- 0 SHIFT_R: seed bit N-1; next = led>>1.
- 1 SHIFT_L: seed bit 0; next = led<<1.
- 2 FILL_R: seed bit N-1; next = (led>>1) | seed.
- 3 FILL_L: seed bit 0; next = (led<<1) | seed.
- 4 SHIFT_OUT: seed bits N/2 and N/2-1; next H = H<<1 and next L = L>>1, each within its half.
- 5 SHIFT_IN: seed bits N-1 and 0; next H = H>>1 and next L = L<<1, each within its half.
- 6 FILL_OUT: as mode 4, with the result ORed with the seed.
- 7 FILL_IN: as mode 5, with the result ORed with the seed.
REQ-013 Prescaler: counter cnt SHALL advance only while en=1. tick SHALL be asserted when cnt == period, and cnt SHALL return to 0 on that cycle. period=0 SHALL give a tick every en cycle.
REQ-014 A period change SHALL take effect at the next comparison. If cnt > period, cnt SHALL wrap through all-ones back to 0.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE. All updates below SHALL occur only on tick with en=1.
REQ-016 IDLE: led SHALL be 0. On tick, led SHALL load the seed and the FSM SHALL enter RUN.
REQ-017 RUN, shift modes (0, 1, 4, 5):
- led != 0: led <= next.
- led == 0, repeat=1: led <= seed and wrap SHALL pulse.
- led == 0, repeat=0: FSM enters DONE.
REQ-018 RUN, fill modes (2, 3, 6, 7):
- led != all-ones: led <= next.
- led == all-ones, repeat=1: led <= 0 for one step, then the REQ-017 reload applies, including the wrap pulse.
- led == all-ones, repeat=0: FSM enters DONE.
REQ-019 DONE: led SHALL hold its terminal value (0 for shift modes, all-ones for fill modes), done SHALL be 1, and ticks SHALL be ignored.
REQ-020 The mode input SHALL be registered as mode_q. When mode != mode_q in any state, the engine SHALL in that same cycle:
- update mode_q;
- clear led, cnt and done;
- enter IDLE.
A mode change SHALL take priority over a coincident tick.
REQ-021 Changing repeat from 0 to 1 while in DONE SHALL cause a seed reload at the next tick, with a wrap pulse.
REQ-022 en=0 SHALL hold led, cnt and the FSM state, and SHALL keep wrap at 0. Resuming SHALL continue from the held cnt.
REQ-023 Step latency: led SHALL change on the clock edge on which tick is asserted. wrap SHALL be high exactly on the cycle the seed appears on led.

Reset
REQ-024 On reset=1 the engine SHALL set led=0, done=0, wrap=0, cnt=0, state=IDLE and mode_q=mode. Reset SHALL override every other input, including mid-sequence.

Structure
REQ-025 Package led_pattern_pkg SHALL hold the mode encoding, the FSM state encoding, and the seed and terminal helper constants expressed as functions of N.
REQ-026 The prescaler SHALL be a sub-module, led_tick_prescaler, with parameter DIV_W and ports clk, reset, en, period, tick.
REQ-027 Next-state pattern logic SHALL be purely combinational. led, done and wrap SHALL be driven from registers only.

Verification
REQ-028 N=8, period=0, mode=0, repeat=0, en=1 -> led sequence 00,80,40,20,10,08,04,02,01,00, then done=1 with led held at 00.
REQ-029 N=8, mode=3, repeat=1, period=2 -> a step every 3 cycles: 01,03,07,...,FF,00,01. wrap pulses once, in the cycle where 01 reappears.
REQ-030 N=8, mode=4, repeat=1 -> 18,24,42,81,00,18. mode=7 -> 81,C3,E7,FF, then done if repeat=0.
REQ-031 Drop en to 0 for 10 cycles mid-sequence -> led and cnt unchanged. Stepping resumes at the same phase, with no skipped step.
REQ-032 Change mode from 1 to 2 mid-sequence, coincident with a tick -> led=00 and state IDLE on the next edge. The next tick gives led=80.
REQ-033 N=12, mode=5: assert reset during RUN -> next edge gives led=000, done=0, wrap=0. The sequence restarts with 801 on the first tick after reset is released.
